cram_arbiter: RTL and testbench
===============================

CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, cart RAM byte-address width.
REQ-002 SHALL have parameter FOOTER_WORDS, default 8, RTC footer length in 16-bit words.
REQ-003 SHALL have ports, in this order: clk_sys in 1 system clock; reset_n in 1 synchronous active-low reset.
REQ-004 SHALL have ce_cpu in 1, CPU clock enable, never high two cycles in a row.
REQ-005 SHALL have cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in 8 and cpu_rdata out 8.
REQ-006 SHALL have bk_req in 1 (level, held until ack), bk_we in 1, bk_addr in ADDR_W-1 (word address) and bk_wdata in 16.
REQ-007 SHALL have bk_rdata out 16 and bk_ack out 1 (one-cycle pulse).
REQ-008 SHALL have cram_words in ADDR_W, the number of save words backed by RAM.
REQ-009 SHALL have ram_addr out ADDR_W, ram_we out 1, ram_wdata out 8 and ram_rdata in 8; the RAM is synchronous with 1-cycle read latency.
REQ-010 SHALL have rtc_wr out 1, rtc_addr out 8, rtc_data out 16, rtc_rdata in 16 and busy out 1.

Function
REQ-011 SHALL give the CPU the RAM on every ce_cpu cycle: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_req&cpu_we, all combinational.
REQ-012 SHALL drive cpu_rdata=ram_rdata combinationally.
REQ-013 SHALL use backup FSM states IDLE, LO, LO_W, HI, HI_W, RTC, ACK.
REQ-014 SHALL, in IDLE with bk_req high, latch bk_we, bk_addr and bk_wdata and go to LO or RTC; latching SHALL also occur on ce_cpu cycles.
REQ-015 SHALL, in LO or HI on a ~ce_cpu cycle, drive ram_addr={word,0} or {word,1} with ram_we=latched we and then advance; on a ce_cpu cycle it SHALL hold state.
REQ-016 SHALL use LO_W and HI_W as unconditional single-cycle capture states: on read, bk_rdata[7:0] and bk_rdata[15:8] respectively take ram_rdata.
REQ-017 SHALL store little-endian: low byte at even address, high byte at odd address.
REQ-018 SHALL go HI_W->ACK; ACK SHALL assert bk_ack for one cycle and return to IDLE.
REQ-019 SHALL, with no ce_cpu collision, give bk_ack exactly 5 cycles after the IDLE sampling cycle; each colliding ce_cpu cycle SHALL add exactly 1 cycle.
REQ-020 SHALL treat bk_req still high in the cycle after bk_ack as a new request.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL keep bk_rdata stable from ACK until the next read capture.
REQ-023 SHALL never let a backup access drive ram_we on a ce_cpu cycle.

Reset
REQ-024 SHALL, on reset_n=0 at a clock edge, enter IDLE with bk_ack=0, rtc_wr=0, bk_rdata=16'h0000 and busy=0.
REQ-025 SHALL force ram_we=0 while reset_n=0, regardless of ce_cpu.
REQ-026 SHALL abandon an in-flight request without ack; the requester reissues it.

Configuration
REQ-027 SHALL, with CRAM_ARB_RTC_FOOTER_EN defined, route any latched bk_addr >= cram_words to RTC with off=bk_addr-cram_words.
REQ-028 SHALL, in RTC with off<FOOTER_WORDS: on write, pulse rtc_wr for 1 cycle with rtc_addr=off[7:0] and rtc_data=bk_wdata; on read, capture bk_rdata=rtc_rdata (rtc_addr=off); then go to ACK, with no RAM access.
REQ-029 SHALL, in RTC with off>=FOOTER_WORDS, drop writes, return 16'hFFFF on reads, and go to ACK.
REQ-030 SHALL, without the macro, send bk_addr>=cram_words to RTC, drop writes, return 16'hFFFF on reads, tie rtc_wr=0, and still ack.

Structure
REQ-031 SHALL place the FSM state enum and the FOOTER_WORDS default in shared package gb_cram_arb_pkg.
REQ-032 SHALL be a single module with no sub-module.

Verification
REQ-033 SHALL cover: bk write addr 0x10, data 0xBEEF, no ce_cpu -> RAM byte 0x20=0xEF, byte 0x21=0xBE, bk_ack 5 cycles after sample.
REQ-034 SHALL cover: ce_cpu in the LO cycle with CPU write to 0x0040=0x5A -> CPU write lands, bk_ack at 6 cycles, no RAM write on the ce_cpu cycle.
REQ-035 SHALL cover: bk read word 0x10 after REQ-033 -> bk_rdata=0xBEEF at ack.
REQ-036 SHALL cover, with the macro: cram_words=0x1000, bk write 0x1002=0x1234 -> single rtc_wr pulse, rtc_addr=2, rtc_data=0x1234, no ram_we.
REQ-037 SHALL cover, without the macro: same write -> rtc_wr stays 0; read of 0x1002 returns 0xFFFF with ack.
REQ-038 SHALL cover: reset_n low during HI -> IDLE, no bk_ack, busy=0 next cycle; a reissued request completes normally.

Source files
------------

// File: rtl/gb_cram_arb_pkg.sv
// Shared types and defaults for the cart RAM backup arbiter.
package gb_cram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        LO_W = 3'd2,
        HI   = 3'd3,
        HI_W = 3'd4,
        RTC  = 3'd5,
        ACK  = 3'd6
    } arb_state_e;

    localparam int FOOTER_WORDS_DEF = 8;

endpackage

// File: rtl/cram_arbiter.sv
// Shares cart RAM between the CPU and a 16-bit backup port, CPU always first.
// Define CRAM_ARB_RTC_FOOTER_EN to map words past cram_words onto the RTC footer.
module cram_arbiter
    import gb_cram_arb_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int FOOTER_WORDS = FOOTER_WORDS_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_cpu,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [ADDR_W-2:0] bk_addr,
    input  logic [15:0]       bk_wdata,
    output logic [15:0]       bk_rdata,
    output logic              bk_ack,
    input  logic [ADDR_W-1:0] cram_words,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              rtc_wr,
    output logic [7:0]        rtc_addr,
    output logic [15:0]       rtc_data,
    input  logic [15:0]       rtc_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] FOOT_LIM = ADDR_W'(FOOTER_WORDS);

    arb_state_e state;
    arb_state_e next;

    logic              lat_we;
    logic [ADDR_W-2:0] lat_addr;
    logic [15:0]       lat_wdata;

    logic [ADDR_W-1:0] off;
    logic              to_rtc;
    logic              in_footer;
    logic              bk_slot;
    logic              hi_sel;
    logic [15:0]       rtc_read;

    assign to_rtc    = {1'b0, bk_addr} >= cram_words;
    assign off       = {1'b0, lat_addr} - cram_words;
    assign in_footer = off < FOOT_LIM;
    assign hi_sel    = (state == HI);
    // Backup only touches the RAM when the CPU is not using its slot.
    assign bk_slot   = ((state == LO) || (state == HI)) && !ce_cpu;

    assign cpu_rdata = ram_rdata;
    assign busy      = (state != IDLE);
    assign bk_ack    = (state == ACK);
    assign rtc_addr  = off[7:0];
    assign rtc_data  = lat_wdata;

`ifdef CRAM_ARB_RTC_FOOTER_EN
    assign rtc_wr   = (state == RTC) && lat_we && in_footer;
    assign rtc_read = in_footer ? rtc_rdata : 16'hFFFF;
`else
    logic unused_rtc;
    assign unused_rtc = ^{rtc_rdata, in_footer};
    assign rtc_wr     = 1'b0;
    assign rtc_read   = 16'hFFFF;
`endif

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = ce_cpu & cpu_req & cpu_we;
        if (bk_slot) begin
            ram_addr  = {lat_addr, hi_sel};
            ram_wdata = hi_sel ? lat_wdata[15:8] : lat_wdata[7:0];
            ram_we    = lat_we;
        end
        if (!reset_n) begin
            ram_we = 1'b0;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (bk_req) next = to_rtc ? RTC : LO;
            LO:      if (!ce_cpu) next = LO_W;
            LO_W:    next = HI;
            HI:      if (!ce_cpu) next = HI_W;
            HI_W:    next = ACK;
            RTC:     next = ACK;
            ACK:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 16'h0000;
            bk_rdata  <= 16'h0000;
        end else begin
            state <= next;
            if ((state == IDLE) && bk_req) begin
                lat_we    <= bk_we;
                lat_addr  <= bk_addr;
                lat_wdata <= bk_wdata;
            end
            // Read data arrives the cycle after the address slot.
            unique case (state)
                LO_W:    if (!lat_we) bk_rdata[7:0]  <= ram_rdata;
                HI_W:    if (!lat_we) bk_rdata[15:8] <= ram_rdata;
                RTC:     if (!lat_we) bk_rdata       <= rtc_read;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed bench for cram_arbiter with a byte RAM and RTC footer model.
module tb_cram_arbiter;

    logic        clk_sys;
    logic        reset_n;
    logic        ce_cpu;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        bk_req;
    logic        bk_we;
    logic [15:0] bk_addr;
    logic [15:0] bk_wdata;
    logic [15:0] bk_rdata;
    logic        bk_ack;
    logic [16:0] cram_words;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        rtc_wr;
    logic [7:0]  rtc_addr;
    logic [15:0] rtc_data;
    logic [15:0] rtc_rdata;
    logic        busy;

    int n_cmp;
    int n_bad;

    logic [7:0] mem [0:(1<<17)-1];

    cram_arbiter dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_cpu    (ce_cpu),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .bk_req    (bk_req),
        .bk_we     (bk_we),
        .bk_addr   (bk_addr),
        .bk_wdata  (bk_wdata),
        .bk_rdata  (bk_rdata),
        .bk_ack    (bk_ack),
        .cram_words(cram_words),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rtc_wr    (rtc_wr),
        .rtc_addr  (rtc_addr),
        .rtc_data  (rtc_data),
        .rtc_rdata (rtc_rdata),
        .busy      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        for (int i = 0; i < (1 << 17); i++) mem[i] = 8'h00;
    end

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    assign rtc_rdata = {8'hA5, rtc_addr};

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ce_cyc;
        logic        cpu_wr;
        logic        chk_rd;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_pulses;
        int          exp_ramwr;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          cyc;
        int          lat;
        int          pulses;
        int          ramwr;
        int          viol;
        logic [15:0] rd;
        logic [7:0]  ra;
        logic [15:0] rdat;
        logic [15:0] exp_off;
        cyc = 0; lat = -1; pulses = 0; ramwr = 0; viol = 0;
        rd = 16'h0; ra = 8'h0; rdat = 16'h0;
        bk_req = 1'b1;
        bk_we = v.we;
        bk_addr = v.addr;
        bk_wdata = v.wdata;
        while (lat < 0 && cyc < 20) begin
            @(negedge clk_sys);
            cyc++;
            ce_cpu = (cyc == v.ce_cyc);
            cpu_req = ce_cpu;
            cpu_we = ce_cpu & v.cpu_wr;
            #1;
            if (cyc == 1) chk({nm, "_busy"}, 32'(busy), 32'd1);
            if (ram_we && !ce_cpu) ramwr++;
            if (ce_cpu && (ram_addr != cpu_addr || ram_we != v.cpu_wr))
                viol++;
            if (rtc_wr) begin
                pulses++;
                ra = rtc_addr;
                rdat = rtc_data;
            end
            if (bk_ack) begin
                lat = cyc;
                rd = bk_rdata;
            end
        end
        bk_req = 1'b0;
        ce_cpu = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_ramwr"}, 32'(ramwr), 32'(v.exp_ramwr));
        chk({nm, "_rtcwr"}, 32'(pulses), 32'(v.exp_pulses));
        chk({nm, "_cpuslot"}, 32'(viol), 32'd0);
        if (v.chk_rd) chk({nm, "_rdata"}, 32'(rd), 32'(v.exp_rd));
        if (pulses > 0) begin
            exp_off = v.addr - 16'h1000;
            chk({nm, "_rtcaddr"}, 32'(ra), 32'(exp_off[7:0]));
            chk({nm, "_rtcdata"}, 32'(rdat), 32'(v.wdata));
        end
        @(negedge clk_sys);
        #1;
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        chk({nm, "_ackpulse"}, 32'(bk_ack), 32'd0);
    endtask

    logic [15:0] rd_1002;
    logic [15:0] rd_1007;
    int          rtc_p;

    initial begin
        int cyc;
        int a1;
        int a2;
        int nack;
        n_cmp = 0;
        n_bad = 0;
`ifdef CRAM_ARB_RTC_FOOTER_EN
        rd_1002 = 16'hA502;
        rd_1007 = 16'hA507;
        rtc_p = 1;
`else
        rd_1002 = 16'hFFFF;
        rd_1007 = 16'hFFFF;
        rtc_p = 0;
`endif
        vt[0]  = '{1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 1'b0, 16'h0, 5, 0, 2};
        vt[1]  = '{1'b1, 16'h0011, 16'h1357, 1, 1'b1, 1'b0, 16'h0, 6, 0, 2};
        vt[2]  = '{1'b0, 16'h0010, 16'h0, 0, 1'b0, 1'b1, 16'hBEEF, 5, 0, 0};
        vt[3]  = '{1'b0, 16'h0011, 16'h0, 3, 1'b0, 1'b1, 16'h1357, 6, 0, 0};
        vt[4]  = '{1'b1, 16'h0FFF, 16'hCAFE, 0, 1'b0, 1'b0, 16'h0, 5, 0, 2};
        vt[5]  = '{1'b0, 16'h0FFF, 16'h0, 0, 1'b0, 1'b1, 16'hCAFE, 5, 0, 0};
        vt[6]  = '{1'b1, 16'h1002, 16'h1234, 0, 1'b0, 1'b0, 16'h0, 2, rtc_p, 0};
        vt[7]  = '{1'b0, 16'h1002, 16'h0, 0, 1'b0, 1'b1, rd_1002, 2, 0, 0};
        vt[8]  = '{1'b1, 16'h1009, 16'h5555, 0, 1'b0, 1'b0, 16'h0, 2, 0, 0};
        vt[9]  = '{1'b0, 16'h1009, 16'h0, 0, 1'b0, 1'b1, 16'hFFFF, 2, 0, 0};
        vt[10] = '{1'b0, 16'h1007, 16'h0, 1, 1'b1, 1'b1, rd_1007, 2, 0, 0};

        reset_n = 1'b0;
        ce_cpu = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 17'h00040;
        cpu_wdata = 8'h5A;
        bk_req = 1'b0;
        bk_we = 1'b0;
        bk_addr = 16'h0;
        bk_wdata = 16'h0;
        cram_words = 17'h01000;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        chk("rst_ramwe", 32'(ram_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(bk_ack), 32'd0);
        chk("rst_rtcwr", 32'(rtc_wr), 32'd0);
        chk("rst_rdata", 32'(bk_rdata), 32'd0);
        ce_cpu = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        reset_n = 1'b1;
        @(negedge clk_sys);

        for (int i = 0; i < 11; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        chk("mem20", 32'(mem[17'h20]), 32'h EF);
        chk("mem21", 32'(mem[17'h21]), 32'h BE);
        chk("mem22", 32'(mem[17'h22]), 32'h57);
        chk("mem23", 32'(mem[17'h23]), 32'h13);
        chk("mem40", 32'(mem[17'h40]), 32'h5A);
        chk("mem1ffe", 32'(mem[17'h1FFE]), 32'hFE);
        chk("mem1fff", 32'(mem[17'h1FFF]), 32'hCA);

        // Request held through ack becomes a second request.
        bk_req = 1'b1;
        bk_we = 1'b0;
        bk_addr = 16'h0010;
        cyc = 0; a1 = 0; a2 = 0;
        while (a2 == 0 && cyc < 30) begin
            @(negedge clk_sys);
            cyc++;
            #1;
            if (bk_ack) begin
                if (a1 == 0) a1 = cyc;
                else a2 = cyc;
            end
        end
        bk_req = 1'b0;
        chk("b2b_ack1", 32'(a1), 32'd5);
        chk("b2b_ack2", 32'(a2), 32'd11);
        chk("b2b_rdata", 32'(bk_rdata), 32'hBEEF);
        @(negedge clk_sys);

        // Reset lands while the high byte is pending.
        bk_req = 1'b1;
        bk_we = 1'b1;
        bk_addr = 16'h0030;
        bk_wdata = 16'h4321;
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rsthi_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        bk_req = 1'b0;
        #1;
        chk("rsthi_ramwe", 32'(ram_we), 32'd0);
        @(negedge clk_sys);
        ce_cpu = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        #1;
        chk("rsthi_idle", 32'(busy), 32'd0);
        chk("rsthi_noack", 32'(bk_ack), 32'd0);
        chk("rsthi_cpuwe", 32'(ram_we), 32'd0);
        chk("rsthi_rdata", 32'(bk_rdata), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        ce_cpu = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            #1;
            if (bk_ack || busy) nack++;
        end
        chk("rsthi_quiet", 32'(nack), 32'd0);
        run_vec('{1'b1, 16'h0030, 16'h4321, 0, 1'b0, 1'b0, 16'h0, 5, 0, 2},
                "reissue_wr");
        run_vec('{1'b0, 16'h0030, 16'h0, 0, 1'b0, 1'b1, 16'h4321, 5, 0, 0},
                "reissue_rd");
        chk("mem60", 32'(mem[17'h60]), 32'h21);
        chk("mem61", 32'(mem[17'h61]), 32'h43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
